// File: rtl/tlc_pkg.sv
// Shared definitions for the multiphase traffic light controller:
// lamp encodings, controller states and round-robin phase selection.
package tlc_pkg;

   // Per-phase lamp encoding, ordered {G,Y,R}
   localparam logic [2:0] LIGHT_GREEN  = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b001;
   localparam logic [2:0] LIGHT_DARK   = 3'b000;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2,
      FLASH   = 2'd3
   } tlc_state_e;

   // Pick the first phase with demand, scanning cur+1 .. cur+n (mod n).
   // The current phase comes last, so a lone demand on it re-serves it.
   // Without any demand the next phase in order is recalled.
   function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                             input logic [7:0] demand,
                                             input int         n);
      logic [2:0] sel;
      logic [2:0] idx;
      sel = 3'((int'(cur) + 1) % n);
      // Walk backwards so the nearest demanding phase is written last
      for (int k = 8; k >= 1; k--) begin
         if (k <= n) begin
            idx = 3'((int'(cur) + k) % n);
            if (demand[idx]) begin
               sel = idx;
            end
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/tlc_ped_channel.sv
// One pedestrian channel: a lock-out counter after each walk interval
// and the latched call that requests service for this phase.
module tlc_ped_channel
   import tlc_pkg::*;
#(
   parameter int PED_DELAY_TIME = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ped_req,
   input  logic walk,
   input  logic green_entry,
   output logic ped_latch
);

   localparam int CW = (PED_DELAY_TIME < 1) ? 1 : $clog2(PED_DELAY_TIME + 1);
   localparam logic [CW-1:0] DELAY_MAX = CW'(PED_DELAY_TIME);

   logic [CW-1:0] delay_cnt_reg;
   logic          ped_latch_reg;

   // Lock-out counter: held at zero while walking, then counts up and saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delay_cnt_reg <= DELAY_MAX;
      end else if (walk) begin
         delay_cnt_reg <= '0;
      end else if (delay_cnt_reg != DELAY_MAX) begin
         delay_cnt_reg <= delay_cnt_reg + 1'b1;
      end
   end

   // Call latch: serving the phase clears it, and that clear beats a new press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_latch_reg <= 1'b0;
      end else if (green_entry) begin
         ped_latch_reg <= 1'b0;
      end else if (ped_req && !walk && (delay_cnt_reg == DELAY_MAX)) begin
         ped_latch_reg <= 1'b1;
      end
   end

   assign ped_latch = ped_latch_reg;

endmodule

// File: rtl/tlc_multiphase.sv
// N-phase demand-actuated traffic light controller with pedestrian calls,
// early green termination and a flashing-red fallback.
module tlc_multiphase
   import tlc_pkg::*;
#(
   parameter int NUM_PHASES        = 4,
   parameter int TIMER_W           = 16,
   parameter int YELLOW_TIME       = 30,
   parameter int ALL_RED_TIME      = 5,
   parameter int MIN_GREEN_TIME    = 50,
   parameter int PED_DELAY_TIME    = 50,
   parameter int FLASH_HALF_PERIOD = 10
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PHASES*TIMER_W-1:0]   green_time_cfg,
   input  logic [NUM_PHASES-1:0]           veh_req,
   input  logic [NUM_PHASES-1:0]           ped_req,
   input  logic                            flash_mode,
   output logic [NUM_PHASES*3-1:0]         light,
   output logic [NUM_PHASES-1:0]           walk,
   output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
   output logic                            in_flash
);

   localparam int PW = $clog2(NUM_PHASES);
   localparam int FW = $clog2(FLASH_HALF_PERIOD) + 1;

   tlc_state_e          state_reg, state_next;
   logic [TIMER_W-1:0]  timer_reg, timer_next;
   logic [TIMER_W-1:0]  green_len_reg, green_len_next;
   logic [PW-1:0]       active_reg, active_next;
   logic [FW-1:0]       flash_cnt_reg;
   logic                flash_dark_reg;

   logic [PW-1:0]         sel_phase;
   logic [TIMER_W-1:0]    sel_cfg;
   logic [TIMER_W-1:0]    cfg_arr [NUM_PHASES];
   logic [NUM_PHASES-1:0] ped_latch;
   logic [NUM_PHASES-1:0] green_entry;
   logic                  green_start;
   logic                  ped_other;

   // Candidate phase for the next green and its configured duration
   assign sel_phase = PW'(next_phase(3'(active_reg), 8'(veh_req | ped_latch), NUM_PHASES));
   assign sel_cfg   = cfg_arr[sel_phase];

   // A waiting pedestrian on any phase other than the one being served
   assign ped_other = |(ped_latch & ~(NUM_PHASES'(1) << active_reg));

   // Next-state logic, green entry and timer update
   always_comb begin
      state_next     = state_reg;
      active_next    = active_reg;
      green_len_next = green_len_reg;
      green_start    = 1'b0;
      case (state_reg)
         ALL_RED: begin
            if (timer_reg == TIMER_W'(ALL_RED_TIME - 1)) begin
               if (flash_mode) begin
                  state_next = FLASH;
               end else begin
                  state_next     = GREEN;
                  active_next    = sel_phase;
                  green_len_next = (sel_cfg == '0) ? TIMER_W'(1) : sel_cfg;
                  green_start    = 1'b1;
               end
            end
         end
         GREEN: begin
            if ((timer_reg == green_len_reg - 1'b1) || flash_mode ||
                (ped_other && (timer_reg >= TIMER_W'(MIN_GREEN_TIME - 1)))) begin
               state_next = YELLOW;
            end
         end
         YELLOW: begin
            if (timer_reg == TIMER_W'(YELLOW_TIME - 1)) begin
               state_next = ALL_RED;
            end
         end
         FLASH: begin
            if (!flash_mode) begin
               state_next = ALL_RED;
            end
         end
         default: state_next = ALL_RED;
      endcase
      timer_next = (state_next != state_reg) ? '0 : timer_reg + 1'b1;
   end

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ALL_RED;
         timer_reg     <= '0;
         active_reg    <= PW'(NUM_PHASES - 1);
         green_len_reg <= TIMER_W'(1);
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         active_reg    <= active_next;
         green_len_reg <= green_len_next;
      end
   end

   // Flash cadence: restarts on RED at every entry into FLASH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flash_cnt_reg  <= '0;
         flash_dark_reg <= 1'b0;
      end else if (state_reg != FLASH) begin
         flash_cnt_reg  <= '0;
         flash_dark_reg <= 1'b0;
      end else if (flash_cnt_reg == FW'(FLASH_HALF_PERIOD - 1)) begin
         flash_cnt_reg  <= '0;
         flash_dark_reg <= ~flash_dark_reg;
      end else begin
         flash_cnt_reg  <= flash_cnt_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
         logic [2:0] head;

         assign cfg_arr[gi]     = green_time_cfg[gi*TIMER_W +: TIMER_W];
         assign green_entry[gi] = green_start && (sel_phase == PW'(gi));
         assign walk[gi]        = (state_reg == GREEN) && (active_reg == PW'(gi));

         // Signal head for this phase
         always_comb begin
            head = LIGHT_RED;
            if (state_reg == FLASH) begin
               head = flash_dark_reg ? LIGHT_DARK : LIGHT_RED;
            end else if (active_reg == PW'(gi)) begin
               if (state_reg == GREEN) begin
                  head = LIGHT_GREEN;
               end else if (state_reg == YELLOW) begin
                  head = LIGHT_YELLOW;
               end
            end
         end

         assign light[gi*3 +: 3] = head;

         tlc_ped_channel #(
            .PED_DELAY_TIME (PED_DELAY_TIME)
         ) u_ped (
            .clk         (clk),
            .rst_n       (rst_n),
            .ped_req     (ped_req[gi]),
            .walk        (walk[gi]),
            .green_entry (green_entry[gi]),
            .ped_latch   (ped_latch[gi])
         );
      end
   endgenerate

   assign active_phase = active_reg;
   assign in_flash     = (state_reg == FLASH);

endmodule

// File: doc/tlc_multiphase.md
Name: tlc_multiphase

Overview:
- N-phase traffic light controller. Each phase is an approach group with its own signal head and pedestrian crosswalk.
- Adds several things the current 2-phase controller lacks:
  - per-phase green times configurable at run time
  - demand-actuated phase skipping, driven by vehicle detectors and latched pedestrian calls
  - early green termination when another phase has a pedestrian call
  - a safe flashing-red fallback mode
- Sits between the intersection I/O (detectors, buttons, maintenance switch) and the lamp drivers.

Parameters:
- NUM_PHASES, 4: number of phases, 2..8.
- TIMER_W, 16: width of the state timer and of each green-time config field.
- YELLOW_TIME, 30: yellow duration in cycles, ≥1.
- ALL_RED_TIME, 5: all-red clearance duration in cycles, ≥1.
- MIN_GREEN_TIME, 50: minimum green in cycles before early termination is allowed, ≥1.
- PED_DELAY_TIME, 50: cycles after a phase's walk ends before a new press on that phase is accepted.
- FLASH_HALF_PERIOD, 10: cycles for each on and off half of the flashing red.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- green_time_cfg, input, NUM_PHASES*TIMER_W: green duration per phase; phase i occupies bits [i*TIMER_W +: TIMER_W]. Sampled on green entry.
- veh_req, input, NUM_PHASES: vehicle detector presence per phase, level.
- ped_req, input, NUM_PHASES: pedestrian button per phase, level.
- flash_mode, input, 1: request for flashing-red operation.
- light, output, NUM_PHASES*3: per-phase lamps, {G,Y,R}; phase i occupies bits [i*3 +: 3].
- walk, output, NUM_PHASES: walk indication per phase.
- active_phase, output, $clog2(NUM_PHASES): current or most recent phase pointer.
- in_flash, output, 1: high while in the FLASH state.

Behaviour:

Light encoding:
- GREEN = 3'b100, YELLOW = 3'b010, RED = 3'b001, DARK = 3'b000.
- Only the phase at active_phase may be non-red. All other phases show RED, except during FLASH.

Outputs:
- All outputs are combinational from registered state.

Reset:
- State ALL_RED, timer 0, active_phase = NUM_PHASES-1, ped latches 0, ped delay counters saturated (presses accepted).
- Output values in reset: all lights RED, walk 0, in_flash 0.

Timer:
- Clears to 0 on every state change and otherwise increments.
- A state of duration D lasts exactly D cycles: it exits when timer == D-1.
- green_time_cfg = 0 is treated as 1.

States and transitions:
- ALL_RED, duration ALL_RED_TIME. At the end:
  - if flash_mode is high, go to FLASH;
  - otherwise select the next phase and go to GREEN.
- Next-phase selection:
  - scan (p+1)…(p+NUM_PHASES) mod NUM_PHASES, where p = active_phase;
  - pick the first phase with veh_req or ped_latch set;
  - if no phase has demand, pick (p+1) mod N (fixed recall).
  - The current phase is scanned last, so a lone demand on it re-serves it.
- GREEN:
  - Light is GREEN on the active phase and walk[active] = 1.
  - Exits to YELLOW when any of the following holds:
    - the timer reaches green_cfg-1;
    - flash_mode is high (immediate exit, MIN_GREEN waived);
    - ped_latch[j] is set for some j ≠ active and timer ≥ MIN_GREEN_TIME-1.
- YELLOW, duration YELLOW_TIME: light is YELLOW, walk 0, then go to ALL_RED.
- FLASH:
  - All phases alternate RED and DARK, starting RED, toggling every FLASH_HALF_PERIOD cycles.
  - walk 0, in_flash 1.
  - When flash_mode is low, exit to ALL_RED on the next cycle. active_phase is unchanged.

Pedestrian channel (per phase i):
- Delay counter:
  - clears while walk[i] is high;
  - otherwise increments, saturating at PED_DELAY_TIME.
- ped_latch[i]:
  - sets when ped_req[i] is high, walk[i] is low and the counter equals PED_DELAY_TIME;
  - clears on the cycle GREEN is entered for phase i.
  - Clear wins over a simultaneous set.
- Presses during walk[i] are ignored.
- Latches persist through FLASH.

Reset mid-operation:
- Returns to the reset values immediately and asynchronously. No yellow is shown.

Decomposition:
- Package tlc_pkg:
  - light encoding constants;
  - state enum {ALL_RED, GREEN, YELLOW, FLASH};
  - a function for next-phase round-robin selection.
- Sub-module tlc_ped_channel, instantiated NUM_PHASES times:
  - holds the delay counter and latch;
  - ports clk, rst_n, ped_req, walk, green_entry, ped_latch.

Test Plan:
Common parameters: NUM_PHASES=4, YELLOW_TIME=3, ALL_RED_TIME=2, MIN_GREEN_TIME=4, PED_DELAY_TIME=5, FLASH_HALF_PERIOD=2, all green_time_cfg=10.

1. No demand, release reset at cycle 0 → cycles 0-1 all RED; phase 0 GREEN cycles 2-11; YELLOW 12-14; all RED 15-16; phase 1 GREEN at cycle 17.
2. veh_req = 4'b1000 held from reset → phases 0-2 skipped; phase 3 GREEN at cycle 2, and phase 3 GREEN again after each all-red.
3. In phase 0 GREEN, pulse ped_req[2] at green timer 1 → YELLOW starts once timer = 3 (4 green cycles); next GREEN is phase 2; walk[2] = 1 and ped_latch[2] clears.
4. Press ped_req[0] while walk[0] = 1, then again 3 cycles after walk[0] falls → both presses ignored; a press 5 cycles after the fall is latched.
5. Raise flash_mode at green timer 1 → YELLOW next cycle, then ALL_RED 2 cycles, then FLASH with lights RED/DARK toggling every 2 cycles; drop flash_mode → ALL_RED then GREEN on the next phase in round-robin order.
6. Assert rst_n low during YELLOW → all lights RED and walk 0 asynchronously; after release, phase 0 GREEN at cycle 2.
